finger_uart_reporter: RTL and testbench

- Parametrised successor to the fixed 4-input finger decoder path. Synchronises and debounces N finger-sensor inputs and encodes the stable pattern into a status byte.
- Pushes the byte to the board UART transmitter over a valid/ready handshake, with rate limiting and coalescing.
- Drives a registered 7-segment digit showing the current encoded finger index.
- Sits between the finger-sensor pins and the UART TX byte interface in the top level.

---
 rtl/finger_uart_reporter.sv | 178 +++++++++++++++++
 tb/tb_finger_uart_reporter.sv | 191 +++++++++++++++++++
 2 files changed

// File: rtl/finger_uart_reporter.sv
// Debounces N finger inputs, encodes them into a status byte and sends it over valid/ready with gap + coalescing.
// Latency: input to stable 2+DEBOUNCE_CYCLES, stable to tx_valid 1 cycle; tx_data held while tx_ready is low.
module finger_uart_reporter #(
    parameter int N_DEDOS         = 4,
    parameter int DEBOUNCE_CYCLES = 50000,
    parameter int MIN_GAP         = 5000,
    parameter bit SEG_ACTIVE_LOW  = 1'b1
) (
    input  logic               clock,
    input  logic               reset_n,
    input  logic [N_DEDOS-1:0] entrada_dedos,
    output logic [7:0]         tx_data,
    output logic               tx_valid,
    input  logic               tx_ready,
    output logic [N_DEDOS-1:0] stable_dedos,
    output logic               multi_press,
    output logic [6:0]         seg_dedos,
    output logic [7:0]         tx_count
);

    localparam int CW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES + 1) : 1;
    localparam int GW = (MIN_GAP > 1) ? $clog2(MIN_GAP + 1) : 1;
    localparam logic [CW-1:0] DEB_LAST = CW'(DEBOUNCE_CYCLES - 1);
    localparam logic [GW-1:0] GAP_LAST = GW'((MIN_GAP > 0) ? MIN_GAP - 1 : 0);
    localparam logic [6:0]    SEG_MASK = {7{SEG_ACTIVE_LOW}};

    typedef enum logic [1:0] {ST_IDLE, ST_SEND, ST_GAP} state_t;

    function automatic logic [6:0] seg_decode(input logic [3:0] v);
        logic [6:0] s;
        case (v)
            4'h0: s = 7'h3F;
            4'h1: s = 7'h06;
            4'h2: s = 7'h5B;
            4'h3: s = 7'h4F;
            4'h4: s = 7'h66;
            4'h5: s = 7'h6D;
            4'h6: s = 7'h7D;
            4'h7: s = 7'h07;
            4'h8: s = 7'h7F;
            4'h9: s = 7'h6F;
            4'hA: s = 7'h77;
            4'hB: s = 7'h7C;
            4'hC: s = 7'h39;
            4'hD: s = 7'h5E;
            4'hE: s = 7'h79;
            default: s = 7'h71;
        endcase
        return s;
    endfunction

    logic [N_DEDOS-1:0] sync1_q, sync2_q, stable_q;
    logic [CW-1:0]      deb_cnt_q [N_DEDOS];

    state_t             state_q, state_d;
    logic [7:0]         tx_data_q, tx_data_d;
    logic               tx_valid_q, tx_valid_d;
    logic [N_DEDOS-1:0] snap_q, snap_d;
    logic [N_DEDOS-1:0] last_sent_q, last_sent_d;
    logic [7:0]         tx_count_q, tx_count_d;
    logic [GW-1:0]      gap_cnt_q, gap_cnt_d;
    logic [6:0]         seg_q;
    logic               multi_q;

    logic [3:0] idx;
    logic [3:0] pop;
    logic [2:0] cnt_sat;
    logic       multi;
    logic [7:0] status_byte;

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            sync1_q  <= '0;
            sync2_q  <= '0;
            stable_q <= '0;
            for (int i = 0; i < N_DEDOS; i++) deb_cnt_q[i] <= '0;
        end else begin
            sync1_q <= entrada_dedos;
            sync2_q <= sync1_q;
            for (int i = 0; i < N_DEDOS; i++) begin
                if (sync2_q[i] == stable_q[i]) begin
                    deb_cnt_q[i] <= '0;
                end else if (deb_cnt_q[i] == DEB_LAST) begin
                    stable_q[i]  <= sync2_q[i];
                    deb_cnt_q[i] <= '0;
                end else begin
                    deb_cnt_q[i] <= deb_cnt_q[i] + 1'b1;
                end
            end
        end
    end

    always_comb begin
        idx = 4'd0;
        pop = 4'd0;
        for (int i = 0; i < N_DEDOS; i++) begin
            if (stable_q[i]) idx = 4'(i + 1);
            pop = pop + 4'(stable_q[i]);
        end
        cnt_sat     = (pop > 4'd7) ? 3'd7 : pop[2:0];
        multi       = (pop > 4'd1);
        status_byte = {multi, cnt_sat, idx};
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) state_q <= ST_IDLE;
        else          state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: if (stable_q != last_sent_q) state_d = ST_SEND;
            ST_SEND: if (tx_valid_q && tx_ready) state_d = (MIN_GAP > 0) ? ST_GAP : ST_IDLE;
            ST_GAP:  if (gap_cnt_q == GAP_LAST) state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    // Changes arriving during SEND/GAP are not queued; IDLE re-compares against the latest stable vector.
    always_comb begin
        tx_data_d   = tx_data_q;
        tx_valid_d  = tx_valid_q;
        snap_d      = snap_q;
        last_sent_d = last_sent_q;
        tx_count_d  = tx_count_q;
        gap_cnt_d   = gap_cnt_q;
        case (state_q)
            ST_IDLE: begin
                if (stable_q != last_sent_q) begin
                    tx_data_d  = status_byte;
                    snap_d     = stable_q;
                    tx_valid_d = 1'b1;
                end
            end
            ST_SEND: begin
                if (tx_valid_q && tx_ready) begin
                    last_sent_d = snap_q;
                    tx_count_d  = tx_count_q + 8'd1;
                    tx_valid_d  = 1'b0;
                    gap_cnt_d   = '0;
                end
            end
            ST_GAP:  gap_cnt_d = gap_cnt_q + 1'b1;
            default: ;
        endcase
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            tx_data_q   <= '0;
            tx_valid_q  <= 1'b0;
            snap_q      <= '0;
            last_sent_q <= '0;
            tx_count_q  <= '0;
            gap_cnt_q   <= '0;
            seg_q       <= 7'h3F ^ SEG_MASK;
            multi_q     <= 1'b0;
        end else begin
            tx_data_q   <= tx_data_d;
            tx_valid_q  <= tx_valid_d;
            snap_q      <= snap_d;
            last_sent_q <= last_sent_d;
            tx_count_q  <= tx_count_d;
            gap_cnt_q   <= gap_cnt_d;
            seg_q       <= seg_decode(idx) ^ SEG_MASK;
            multi_q     <= multi;
        end
    end

    assign tx_data      = tx_data_q;
    assign tx_valid     = tx_valid_q;
    assign tx_count     = tx_count_q;
    assign stable_dedos = stable_q;
    assign seg_dedos    = seg_q;
    assign multi_press  = multi_q;

endmodule

// File: tb/tb_finger_uart_reporter.sv
// Directed stimulus with a byte scoreboard; a negedge monitor checks every accepted byte and stalled-data hold.
module tb_finger_uart_reporter;

    logic       clock = 1'b0;
    logic       reset_n = 1'b0;
    logic [3:0] entrada_dedos = 4'b0000;
    logic       tx_ready = 1'b1;
    logic [7:0] tx_data;
    logic       tx_valid;
    logic [3:0] stable_dedos;
    logic       multi_press;
    logic [6:0] seg_dedos;
    logic [7:0] tx_count;

    int checks = 0;
    int errors = 0;
    logic [7:0] exp_q[$];

    finger_uart_reporter #(
        .N_DEDOS(4), .DEBOUNCE_CYCLES(4), .MIN_GAP(3), .SEG_ACTIVE_LOW(1'b1)
    ) dut (
        .clock(clock), .reset_n(reset_n), .entrada_dedos(entrada_dedos),
        .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready),
        .stable_dedos(stable_dedos), .multi_press(multi_press),
        .seg_dedos(seg_dedos), .tx_count(tx_count)
    );

    always #5 clock = ~clock;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clock);
        #1;
    endtask

    // Monitor: pops one expected byte per handshake and checks stalled bytes stay put.
    logic       stall_q = 1'b0;
    logic [7:0] stall_dat = 8'h00;
    always @(negedge clock) begin
        if (!reset_n) begin
            stall_q = 1'b0;
        end else begin
            if (stall_q) begin
                checks++;
                if (!tx_valid || tx_data !== stall_dat) begin
                    errors++;
                    $display("FAIL hold: valid=%0b data=0x%0h expected valid=1 data=0x%0h", tx_valid, tx_data, stall_dat);
                end
            end
            if (tx_valid && tx_ready) begin
                checks++;
                if (exp_q.size() == 0) begin
                    errors++;
                    $display("FAIL unexpected_byte: got 0x%0h with no byte expected", tx_data);
                end else begin
                    logic [7:0] e;
                    e = exp_q.pop_front();
                    if (tx_data !== e) begin
                        errors++;
                        $display("FAIL byte: got 0x%0h expected 0x%0h", tx_data, e);
                    end
                end
            end
            stall_q   = tx_valid && !tx_ready;
            stall_dat = tx_data;
        end
    end

    initial begin
        // Reset and idle
        tick(3);
        reset_n = 1'b1;
        check("rst_valid", 32'(tx_valid), 32'h0);
        check("rst_data", 32'(tx_data), 32'h00);
        check("rst_count", 32'(tx_count), 32'h0);
        check("rst_seg", 32'(seg_dedos), 32'h40);
        check("rst_stable", 32'(stable_dedos), 32'h0);
        tick(20);
        check("idle_count", 32'(tx_count), 32'h0);

        // Single press: 0100 -> idx 3, cnt 1
        entrada_dedos = 4'b0100;
        exp_q.push_back(8'h13);
        tick(5);
        check("deb_not_yet", 32'(stable_dedos), 32'h0);
        tick(1);
        check("deb_stable", 32'(stable_dedos), 32'h4);
        check("pre_valid", 32'(tx_valid), 32'h0);
        tick(1);
        check("single_valid", 32'(tx_valid), 32'h1);
        check("single_data", 32'(tx_data), 32'h13);
        check("single_seg", 32'(seg_dedos), 32'b0110000);
        tick(1);
        check("single_pulse", 32'(tx_valid), 32'h0);
        check("single_count", 32'(tx_count), 32'h1);
        tick(10);

        // Glitch of 3 cycles on bit0 is rejected
        entrada_dedos = 4'b0101;
        tick(3);
        entrada_dedos = 4'b0100;
        tick(10);
        check("glitch_stable", 32'(stable_dedos), 32'h4);
        check("glitch_cnt", 32'(dut.deb_cnt_q[0]), 32'h0);
        check("glitch_count", 32'(tx_count), 32'h1);
        check("glitch_valid", 32'(tx_valid), 32'h0);

        // Multi press under backpressure: 1011 -> 0xB4
        tx_ready = 1'b0;
        entrada_dedos = 4'b1011;
        exp_q.push_back(8'hB4);
        tick(7);
        check("multi_valid", 32'(tx_valid), 32'h1);
        check("multi_data", 32'(tx_data), 32'hB4);
        check("multi_press", 32'(multi_press), 32'h1);
        check("multi_seg", 32'(seg_dedos), 32'b0011001);
        tick(20);
        check("bp_valid", 32'(tx_valid), 32'h1);
        check("bp_data", 32'(tx_data), 32'hB4);
        tx_ready = 1'b1;
        tick(1);
        check("bp_accept", 32'(tx_valid), 32'h0);
        check("bp_count", 32'(tx_count), 32'h2);
        tick(6);

        // Coalescing: 0001 stalled, then 0011 and 0010 settle; only 0x11 then 0x12 go out
        tx_ready = 1'b0;
        entrada_dedos = 4'b0001;
        exp_q.push_back(8'h11);
        exp_q.push_back(8'h12);
        tick(8);
        check("coal_first", 32'(tx_data), 32'h11);
        entrada_dedos = 4'b0011;
        tick(8);
        check("coal_mid_stable", 32'(stable_dedos), 32'h3);
        entrada_dedos = 4'b0010;
        tick(8);
        check("coal_last_stable", 32'(stable_dedos), 32'h2);
        check("coal_held", 32'(tx_data), 32'h11);
        tx_ready = 1'b1;
        tick(1);
        check("coal_count1", 32'(tx_count), 32'h3);
        tick(12);
        check("coal_count2", 32'(tx_count), 32'h4);
        check("coal_valid", 32'(tx_valid), 32'h0);
        check("coal_seg", 32'(seg_dedos), 32'b0100100);
        check("coal_multi", 32'(multi_press), 32'h0);
        check("coal_drained", 32'(exp_q.size()), 32'h0);

        // Reset while a byte is stalled
        tx_ready = 1'b0;
        entrada_dedos = 4'b1000;
        tick(7);
        check("mid_valid", 32'(tx_valid), 32'h1);
        check("mid_data", 32'(tx_data), 32'h14);
        #1;
        reset_n = 1'b0;
        #1;
        check("async_valid", 32'(tx_valid), 32'h0);
        check("async_count", 32'(tx_count), 32'h0);
        check("async_stable", 32'(stable_dedos), 32'h0);
        check("async_seg", 32'(seg_dedos), 32'h40);
        tx_ready = 1'b1;
        exp_q.push_back(8'h14);
        tick(3);
        reset_n = 1'b1;
        tick(5);
        check("resync_wait", 32'(stable_dedos), 32'h0);
        tick(1);
        check("resync_stable", 32'(stable_dedos), 32'h8);
        check("resync_novalid", 32'(tx_valid), 32'h0);
        tick(1);
        check("resync_valid", 32'(tx_valid), 32'h1);
        check("resync_data", 32'(tx_data), 32'h14);
        tick(1);
        check("resync_count", 32'(tx_count), 32'h1);
        tick(8);
        check("final_drained", 32'(exp_q.size()), 32'h0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
